// File: rtl/i8255_bus_master.sv
// ============================================================================
// Module   : i8255_bus_master
// Purpose  : Bus-cycle sequencer that turns host valid/ready transfers into
//            timed i8255 PPI strobes, with an optional mode write after reset.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i8255_bus_master #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 1,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 1,
    parameter bit          INIT_EN     = 1'b1,
    parameter logic [7:0]  INIT_MODE   = 8'h80
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [1:0] a,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);

    localparam int unsigned c_max_ab = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned c_max_cd = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int unsigned c_max    = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
    localparam int unsigned c_cnt_w  = (c_max > 1) ? $clog2(c_max) : 1;

    localparam logic [2:0] c_st_init    = 3'd0;
    localparam logic [2:0] c_st_idle    = 3'd1;
    localparam logic [2:0] c_st_setup   = 3'd2;
    localparam logic [2:0] c_st_strobe  = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;
    localparam logic [2:0] c_st_recover = 3'd5;

    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_rnw;
    logic [1:0]         r_addr;
    logic [7:0]         r_wdata;

    logic               r_req_ready;
    logic               r_busy;
    logic               r_cs_n;
    logic               r_rd_n;
    logic               r_wr_n;
    logic [1:0]         r_a;
    logic [7:0]         r_d_out;
    logic               r_d_oe;
    logic [7:0]         r_rdata;
    logic               r_rdata_valid;

    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_accept;
    logic               w_capture;
    logic               w_rnw_nxt;
    logic [1:0]         w_addr_nxt;
    logic [7:0]         w_wdata_nxt;

    logic               w_req_ready;
    logic               w_busy;
    logic               w_cs_n;
    logic               w_rd_n;
    logic               w_wr_n;
    logic [1:0]         w_a;
    logic [7:0]         w_d_out;
    logic               w_d_oe;

    assign w_accept  = (r_state == c_st_idle) && req_valid && r_req_ready;
    assign w_capture = (r_state == c_st_strobe) && (w_state_nxt == c_st_hold) && r_rnw;

    // Transfer attributes as they will be once this edge has been taken.
    always_comb begin
        w_rnw_nxt   = r_rnw;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        if (r_state == c_st_init) begin
            w_rnw_nxt   = 1'b0;
            w_addr_nxt  = 2'd3;
            w_wdata_nxt = INIT_MODE;
        end else if (w_accept) begin
            w_rnw_nxt   = req_rnw;
            w_addr_nxt  = req_addr;
            w_wdata_nxt = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= INIT_EN ? c_st_init : c_st_idle;
            r_cnt         <= c_cnt_zero;
            r_rnw         <= 1'b0;
            r_addr        <= 2'd0;
            r_wdata       <= 8'd0;
            r_req_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_cs_n        <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_a           <= 2'd0;
            r_d_out       <= 8'd0;
            r_d_oe        <= 1'b0;
            r_rdata       <= 8'd0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rnw         <= w_rnw_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_req_ready   <= w_req_ready;
            r_busy        <= w_busy;
            r_cs_n        <= w_cs_n;
            r_rd_n        <= w_rd_n;
            r_wr_n        <= w_wr_n;
            r_a           <= w_a;
            r_d_out       <= w_d_out;
            r_d_oe        <= w_d_oe;
            r_rdata_valid <= w_capture;
            if (w_capture) begin
                r_rdata <= d_in;
            end
        end
    end

    // Next state and the shared dwell counter, reloaded with N-1 on entry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_init:    w_state_nxt = c_st_setup;
            c_st_idle:    if (w_accept)            w_state_nxt = c_st_setup;
            c_st_setup:   if (r_cnt == c_cnt_zero) w_state_nxt = c_st_strobe;
            c_st_strobe:  if (r_cnt == c_cnt_zero) w_state_nxt = c_st_hold;
            c_st_hold:    if (r_cnt == c_cnt_zero) w_state_nxt = c_st_recover;
            c_st_recover: if (r_cnt == c_cnt_zero) w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase

        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                c_st_setup:   w_cnt_nxt = c_cnt_w'(SETUP_CYC - 1);
                c_st_strobe:  w_cnt_nxt = c_cnt_w'(STROBE_CYC - 1);
                c_st_hold:    w_cnt_nxt = c_cnt_w'(HOLD_CYC - 1);
                c_st_recover: w_cnt_nxt = c_cnt_w'(RECOVER_CYC - 1);
                default:      w_cnt_nxt = c_cnt_zero;
            endcase
        end else if (r_cnt != c_cnt_zero) begin
            w_cnt_nxt = r_cnt - c_cnt_one;
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        w_req_ready = 1'b0;
        w_busy      = 1'b1;
        w_cs_n      = 1'b1;
        w_rd_n      = 1'b1;
        w_wr_n      = 1'b1;
        w_a         = r_a;
        w_d_out     = r_d_out;
        w_d_oe      = 1'b0;
        case (w_state_nxt)
            c_st_idle: begin
                w_req_ready = 1'b1;
                w_busy      = 1'b0;
            end
            c_st_setup: begin
                w_cs_n = 1'b0;
                w_a    = w_addr_nxt;
                w_d_oe = ~w_rnw_nxt;
                if (!w_rnw_nxt) begin
                    w_d_out = w_wdata_nxt;
                end
            end
            c_st_strobe: begin
                w_cs_n = 1'b0;
                w_rd_n = ~w_rnw_nxt;
                w_wr_n = w_rnw_nxt;
                w_d_oe = ~w_rnw_nxt;
            end
            c_st_hold: begin
                w_cs_n = 1'b0;
                w_d_oe = ~w_rnw_nxt;
            end
            default: begin
            end
        endcase
    end

    assign req_ready   = r_req_ready;
    assign busy        = r_busy;
    assign cs_n        = r_cs_n;
    assign rd_n        = r_rd_n;
    assign wr_n        = r_wr_n;
    assign a           = r_a;
    assign d_out       = r_d_out;
    assign d_oe        = r_d_oe;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;

endmodule

`default_nettype wire

// File: tb/tb_i8255_bus_master.sv
// ============================================================================
// Module   : tb_i8255_bus_master
// Purpose  : Directed checks of the PPI bus sequencer with default timing and
//            with stretched timing / no init write.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i8255_bus_master;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       reset_n, req_valid, req_rnw;
    logic [1:0] req_addr;
    logic [7:0] req_wdata, d_in;
    logic       req_ready, rdata_valid, busy, cs_n, rd_n, wr_n, d_oe;
    logic [1:0] a;
    logic [7:0] rdata, d_out;

    // Stretched-timing instance without init write
    logic       reset_n_t, req_valid_t, req_rnw_t;
    logic [1:0] req_addr_t;
    logic [7:0] req_wdata_t, d_in_t;
    logic       req_ready_t, rdata_valid_t, busy_t, cs_n_t, rd_n_t, wr_n_t, d_oe_t;
    logic [1:0] a_t;
    logic [7:0] rdata_t, d_out_t;

    int n_pass = 0;
    int n_chk  = 0;

    i8255_bus_master dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a(a),
        .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
    );

    i8255_bus_master #(
        .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .RECOVER_CYC(2), .INIT_EN(1'b0)
    ) dut_t (
        .clk(clk), .reset_n(reset_n_t), .req_valid(req_valid_t), .req_ready(req_ready_t),
        .req_rnw(req_rnw_t), .req_addr(req_addr_t), .req_wdata(req_wdata_t),
        .rdata(rdata_t), .rdata_valid(rdata_valid_t), .busy(busy_t),
        .cs_n(cs_n_t), .rd_n(rd_n_t), .wr_n(wr_n_t), .a(a_t),
        .d_out(d_out_t), .d_oe(d_oe_t), .d_in(d_in_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int cs_lo;
        int wr_lo;
        int spacing;
        logic prev_cs;

        reset_n = 1'b0; req_valid = 1'b0; req_rnw = 1'b0; req_addr = 2'd0;
        req_wdata = 8'h00; d_in = 8'h00;
        reset_n_t = 1'b0; req_valid_t = 1'b0; req_rnw_t = 1'b0; req_addr_t = 2'd0;
        req_wdata_t = 8'h00; d_in_t = 8'h00;

        // Reset and automatic init write
        tick(); tick(); tick();
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oe", 32'(d_oe), 0);
        reset_n = 1'b1;
        tick();
        chk("init_setup_cs", 32'(cs_n), 0);
        chk("init_a", 32'(a), 3);
        chk("init_d", 32'(d_out), 32'h80);
        chk("init_oe", 32'(d_oe), 1);
        chk("init_setup_wr", 32'(wr_n), 1);
        chk("init_busy", 32'(busy), 1);
        tick();
        chk("init_strobe_wr", 32'(wr_n), 0);
        chk("init_strobe_cs", 32'(cs_n), 0);
        tick();
        chk("init_hold_wr", 32'(wr_n), 1);
        chk("init_hold_cs", 32'(cs_n), 0);
        tick();
        chk("init_rec_cs", 32'(cs_n), 1);
        chk("init_rec_ready", 32'(req_ready), 0);
        tick();
        chk("init_idle_ready", 32'(req_ready), 1);
        chk("init_idle_busy", 32'(busy), 0);

        // Write PA = FF
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 2'd0; req_wdata = 8'hFF;
        tick();
        req_valid = 1'b0;
        chk("wr_setup_cs", 32'(cs_n), 0);
        chk("wr_setup_a", 32'(a), 0);
        chk("wr_setup_d", 32'(d_out), 32'hFF);
        chk("wr_setup_oe", 32'(d_oe), 1);
        chk("wr_setup_ready", 32'(req_ready), 0);
        tick();
        chk("wr_strobe_wr", 32'(wr_n), 0);
        chk("wr_strobe_rd", 32'(rd_n), 1);
        chk("wr_strobe_oe", 32'(d_oe), 1);
        tick();
        chk("wr_hold_cs", 32'(cs_n), 0);
        chk("wr_hold_wr", 32'(wr_n), 1);
        chk("wr_hold_rv", 32'(rdata_valid), 0);
        chk("wr_hold_d", 32'(d_out), 32'hFF);
        tick();
        chk("wr_rec_cs", 32'(cs_n), 1);
        chk("wr_rec_oe", 32'(d_oe), 0);
        tick();
        chk("wr_idle_ready", 32'(req_ready), 1);

        // Read PB returning 5A
        req_valid = 1'b1; req_rnw = 1'b1; req_addr = 2'd1;
        tick();
        req_valid = 1'b0; d_in = 8'h5A;
        chk("rd_setup_cs", 32'(cs_n), 0);
        chk("rd_setup_a", 32'(a), 1);
        chk("rd_setup_oe", 32'(d_oe), 0);
        chk("rd_setup_rd", 32'(rd_n), 1);
        tick();
        chk("rd_strobe_rd", 32'(rd_n), 0);
        chk("rd_strobe_wr", 32'(wr_n), 1);
        chk("rd_strobe_oe", 32'(d_oe), 0);
        tick();
        d_in = 8'h00;
        chk("rd_hold_rdata", 32'(rdata), 32'h5A);
        chk("rd_hold_rv", 32'(rdata_valid), 1);
        chk("rd_hold_rd", 32'(rd_n), 1);
        chk("rd_hold_cs", 32'(cs_n), 0);
        tick();
        chk("rd_rec_rv", 32'(rdata_valid), 0);
        chk("rd_rec_rdata", 32'(rdata), 32'h5A);
        tick();
        chk("rd_idle_ready", 32'(req_ready), 1);

        // Back-to-back writes with req_valid held high
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 2'd2; req_wdata = 8'h0F;
        tick();
        req_addr = 2'd3; req_wdata = 8'h83;
        chk("b2b1_cs", 32'(cs_n), 0);
        chk("b2b1_a", 32'(a), 2);
        chk("b2b1_d", 32'(d_out), 32'h0F);
        tick();
        chk("b2b1_strobe_d", 32'(d_out), 32'h0F);
        chk("b2b1_strobe_a", 32'(a), 2);
        tick();
        chk("b2b1_hold_d", 32'(d_out), 32'h0F);
        chk("b2b1_hold_rv", 32'(rdata_valid), 0);
        tick();
        chk("b2b_gap_cs", 32'(cs_n), 1);
        chk("b2b_gap_ready", 32'(req_ready), 0);
        tick();
        chk("b2b_idle_cs", 32'(cs_n), 1);
        chk("b2b_idle_ready", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        chk("b2b2_cs", 32'(cs_n), 0);
        chk("b2b2_a", 32'(a), 3);
        chk("b2b2_d", 32'(d_out), 32'h83);
        tick(); tick(); tick(); tick();
        chk("b2b_end_ready", 32'(req_ready), 1);
        chk("b2b_rdata_kept", 32'(rdata), 32'h5A);

        // Reset in the middle of a write strobe
        req_valid = 1'b1; req_rnw = 1'b0; req_addr = 2'd0; req_wdata = 8'h55;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_wr_low", 32'(wr_n), 0);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_cs", 32'(cs_n), 1);
        chk("mid_rst_wr", 32'(wr_n), 1);
        chk("mid_rst_oe", 32'(d_oe), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_rdata", 32'(rdata), 0);
        reset_n = 1'b1;
        tick();
        chk("reinit_cs", 32'(cs_n), 0);
        chk("reinit_a", 32'(a), 3);
        chk("reinit_d", 32'(d_out), 32'h80);
        tick();
        chk("reinit_wr", 32'(wr_n), 0);

        // Stretched timing, no init write
        reset_n_t = 1'b1;
        tick();
        chk("t_ready_after_rst", 32'(req_ready_t), 1);
        chk("t_busy_after_rst", 32'(busy_t), 0);
        req_valid_t = 1'b1; req_rnw_t = 1'b0; req_addr_t = 2'd1; req_wdata_t = 8'hA5;
        tick();
        chk("t_setup_cs", 32'(cs_n_t), 0);
        chk("t_setup_d", 32'(d_out_t), 32'hA5);
        cs_lo   = (cs_n_t == 1'b0) ? 1 : 0;
        wr_lo   = (wr_n_t == 1'b0) ? 1 : 0;
        spacing = 0;
        prev_cs = cs_n_t;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i + 1 <= 10) begin
                if (cs_n_t == 1'b0) cs_lo++;
                if (wr_n_t == 1'b0) wr_lo++;
            end
            if (prev_cs == 1'b1 && cs_n_t == 1'b0) begin
                spacing = i;
                break;
            end
            prev_cs = cs_n_t;
        end
        req_valid_t = 1'b0;
        chk("t_cs_low_cycles", 32'(cs_lo), 7);
        chk("t_wr_low_cycles", 32'(wr_lo), 3);
        chk("t_accept_spacing", 32'(spacing), 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
